// File: rtl/lab2_leds.sv
// Registered 4+4-bit unsigned adder driving the 5-LED bar.
// Define LEDS_SYNC_EN to pass both switch banks through 2-flop synchronizers.
module lab2_leds (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] switch1,
  input  logic [3:0] switch2,
  output logic [4:0] leds
);

  logic [3:0] opa_s;
  logic [3:0] opb_s;
  logic [4:0] sum_s;

`ifdef LEDS_SYNC_EN
  logic [3:0] a_meta_r;
  logic [3:0] a_sync_r;
  logic [3:0] b_meta_r;
  logic [3:0] b_sync_r;

  // Two-stage synchronizers for the asynchronous DIP-switch banks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_meta_r <= 4'h0;
      a_sync_r <= 4'h0;
      b_meta_r <= 4'h0;
      b_sync_r <= 4'h0;
    end else begin
      a_meta_r <= switch1;
      a_sync_r <= a_meta_r;
      b_meta_r <= switch2;
      b_sync_r <= b_meta_r;
    end
  end

  assign opa_s = a_sync_r;
  assign opb_s = b_sync_r;
`else
  assign opa_s = switch1;
  assign opb_s = switch2;
`endif

  // Zero-extended add: 15+15 = 30 always fits in 5 bits
  assign sum_s = {1'b0, opa_s} + {1'b0, opb_s};

  // Output register so the LED pins are driven only by flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds <= 5'b00000;
    end else begin
      leds <= sum_s;
    end
  end

endmodule

// File: tb/tb_lab2_leds.sv
// Scoreboard bench for lab2_leds: driver pushes expected sums, monitor pops
// one entry per rising edge once the pipeline latency has elapsed.
module tb_lab2_leds;

`ifdef LEDS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] switch1;
  logic [3:0] switch2;
  logic [4:0] leds;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  logic [4:0] exp_q[$];

  lab2_leds dut (
    .clk     (clk),
    .reset   (reset),
    .switch1 (switch1),
    .switch2 (switch2),
    .leds    (leds)
  );

  // Clock held still at first so the reset check happens with no edges
  initial begin
    clk = 1'b0;
    #40;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: leds=%b expected=%b", name, $time, got, want);
    end
  endtask

  // Monitor: one output per rising edge; zero while held in reset or filling
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edges = 0;
      #1;
      check("reset", leds, 5'b00000);
    end else begin
      edges = edges + 1;
      #1;
      if (edges >= LAT) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL underflow at %0t: leds=%b expected=<none>", $time, leds);
        end else begin
          check("sum", leds, exp_q.pop_front());
        end
      end else begin
        check("fill", leds, 5'b00000);
      end
    end
  end

  task automatic apply(input int a, input int b);
    @(negedge clk);
    switch1 = 4'(a);
    switch2 = 4'(b);
    exp_q.push_back(5'(a + b));
  endtask

  task automatic release_with(input int a, input int b);
    @(negedge clk);
    switch1 = 4'(a);
    switch2 = 4'(b);
    exp_q.push_back(5'(a + b));
    reset = 1'b1;
  endtask

  task automatic hold(input int a, input int b, input int n);
    for (int i = 0; i < n; i++) apply(a, b);
  endtask

  int perm[256];

  initial begin
    reset   = 1'b1;
    switch1 = 4'hF;
    switch2 = 4'hF;
    #10;
    reset = 1'b0;
    #10;
    check("reset_no_clk", leds, 5'b00000);
    #15;
    check("reset_held", leds, 5'b00000);

    release_with(0, 0);
    hold(0, 0, LAT);
    hold(5, 3, LAT + 1);
    hold(15, 15, LAT + 1);
    hold(8, 8, LAT + 1);

    // Full operand sweep in a shuffled order, changing every cycle
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) apply(perm[i] >> 4, perm[i] & 15);

    for (int i = 0; i < 40; i++) apply(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));

    // Mid-cycle reset pulse discards everything in flight
    hold(15, 1, LAT + 2);
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    release_with(15, 1);
    hold(15, 1, LAT + 2);

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
